// File: rtl/fb_scanout_reader.sv
`default_nettype none
// ============================================================================
// Module     : fb_scanout_reader
// Description: PLB read master that streams the front framebuffer, one
//              single-beat read per pixel in raster order, into the pixel FIFO.
// Revision   : 1.0 - initial release
// ============================================================================
module fb_scanout_reader #(
  parameter logic [9:0]              FB_BASE_ADDR = 10'b1001_0000_00,
  parameter int                      LINE_LEN     = 9,
  parameter int                      COL_LEN      = 10,
  parameter logic [LINE_LEN-1:0]     LAST_LINE    = 'd479,
  parameter logic [COL_LEN-1:0]      LAST_COL     = 'd639,
  parameter int                      C_MST_AWIDTH = 32,
  parameter int                      C_MST_DWIDTH = 32,
  parameter logic [C_MST_DWIDTH-1:0] ERR_COLOR    = 32'h0000_0000
) (
  input  logic                      PLB_clk,
  input  logic                      reset,
  input  logic                      Bus2IP_Reset,
  input  logic                      frame_start,
  input  logic                      front_buffer,
  input  logic                      pix_fifo_full,
  output logic                      pix_fifo_wr_en,
  output logic [C_MST_DWIDTH-1:0]   pix_fifo_data,
  output logic                      frame_done,
  output logic                      busy,
  output logic                      IP2Bus_MstRd_Req,
  output logic                      IP2Bus_MstWr_Req,
  output logic [C_MST_AWIDTH-1:0]   IP2Bus_Mst_Addr,
  output logic [C_MST_DWIDTH/8-1:0] IP2Bus_Mst_BE,
  output logic                      IP2Bus_Mst_Lock,
  output logic                      IP2Bus_Mst_Reset,
  output logic [C_MST_DWIDTH-1:0]   IP2Bus_MstWr_d,
  input  logic                      Bus2IP_Mst_CmdAck,
  input  logic                      Bus2IP_Mst_Cmplt,
  input  logic                      Bus2IP_Mst_Error,
  input  logic [C_MST_DWIDTH-1:0]   Bus2IP_MstRd_d,
  input  logic                      Bus2IP_MstRd_src_rdy_n
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_REQ  = 3'd2,
    S_DATA = 3'd3,
    S_PUSH = 3'd4
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_rst;
  logic                      w_last_col;
  logic                      w_last_pix;
  logic                      r_buf_sel;
  logic [LINE_LEN-1:0]       r_line;
  logic [COL_LEN-1:0]        r_col;
  logic [C_MST_DWIDTH-1:0]   r_pix_data;
  logic                      r_rd_req;
  logic                      r_wr_en;
  logic                      r_frame_done;
  logic                      r_busy;

  assign w_rst      = reset | Bus2IP_Reset;
  assign w_last_col = (r_col == LAST_COL);
  assign w_last_pix = w_last_col && (r_line == LAST_LINE);

  always_ff @(posedge PLB_clk) begin
    if (w_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (frame_start)        w_next = S_WAIT;
      S_WAIT: if (!pix_fifo_full)     w_next = S_REQ;
      S_REQ:  if (Bus2IP_Mst_CmdAck)  w_next = S_DATA;
      S_DATA: if (Bus2IP_Mst_Cmplt)   w_next = S_PUSH;
      S_PUSH: w_next = w_last_pix ? S_IDLE : S_WAIT;
      default: w_next = S_IDLE;
    endcase
  end

  // Control outputs are registered copies of the upcoming state so they
  // line up exactly with the state they describe.
  always_ff @(posedge PLB_clk) begin
    if (w_rst) begin
      r_rd_req     <= 1'b0;
      r_wr_en      <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_rd_req     <= (w_next == S_REQ);
      r_wr_en      <= (w_next == S_PUSH);
      r_frame_done <= (r_state == S_PUSH) && w_last_pix;
      r_busy       <= (w_next != S_IDLE);
    end
  end

  always_ff @(posedge PLB_clk) begin
    if (w_rst) begin
      r_buf_sel  <= 1'b0;
      r_line     <= '0;
      r_col      <= '0;
      r_pix_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_buf_sel <= front_buffer;
            r_line    <= '0;
            r_col     <= '0;
          end
        end
        S_DATA: begin
          if (!Bus2IP_MstRd_src_rdy_n)
            r_pix_data <= Bus2IP_MstRd_d;
          // An erroring completion overrides any beat captured in the same cycle.
          if (Bus2IP_Mst_Cmplt && Bus2IP_Mst_Error)
            r_pix_data <= ERR_COLOR;
        end
        S_PUSH: begin
          if (!w_last_col) begin
            r_col <= r_col + COL_LEN'(1);
          end else if (!w_last_pix) begin
            r_col  <= '0;
            r_line <= r_line + LINE_LEN'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign IP2Bus_Mst_Addr  = C_MST_AWIDTH'({FB_BASE_ADDR, r_buf_sel, r_line, r_col, 2'b00});
  assign IP2Bus_MstRd_Req = r_rd_req;
  assign IP2Bus_MstWr_Req = 1'b0;
  assign IP2Bus_Mst_BE    = '1;
  assign IP2Bus_Mst_Lock  = 1'b0;
  assign IP2Bus_Mst_Reset = 1'b0;
  assign IP2Bus_MstWr_d   = '0;
  assign pix_fifo_wr_en   = r_wr_en;
  assign pix_fifo_data    = r_pix_data;
  assign frame_done       = r_frame_done;
  assign busy             = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fb_scanout_reader.sv
`default_nettype none
// ============================================================================
// Module     : tb_fb_scanout_reader
// Description: Scoreboard bench for fb_scanout_reader with a small PLB read model.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_fb_scanout_reader;

  localparam logic [31:0] C_ERR_COLOR = 32'h0000_0000;

  logic        PLB_clk = 1'b0;
  logic        reset = 1'b0;
  logic        Bus2IP_Reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        front_buffer = 1'b0;
  logic        pix_fifo_full = 1'b0;
  logic        pix_fifo_wr_en;
  logic [31:0] pix_fifo_data;
  logic        frame_done;
  logic        busy;
  logic        IP2Bus_MstRd_Req;
  logic        IP2Bus_MstWr_Req;
  logic [31:0] IP2Bus_Mst_Addr;
  logic [3:0]  IP2Bus_Mst_BE;
  logic        IP2Bus_Mst_Lock;
  logic        IP2Bus_Mst_Reset;
  logic [31:0] IP2Bus_MstWr_d;
  logic        bm_ack = 1'b0;
  logic        bm_cmplt = 1'b0;
  logic        tb_cmplt = 1'b0;
  logic        w_cmplt;
  logic        bm_err = 1'b0;
  logic [31:0] bm_data = 32'h0;
  logic        bm_rdy_n = 1'b1;

  assign w_cmplt = bm_cmplt | tb_cmplt;

  int n_cmp = 0;
  int n_err = 0;
  int n_push = 0;
  int n_done = 0;
  int rd_cnt = 0;
  int err_at = -1;
  int ack_delay = 1;
  int bm_mode = 0;   // 0: normal responder, 1: never acknowledges

  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];

  always #5 PLB_clk = ~PLB_clk;

  fb_scanout_reader #(
    .LAST_LINE (9'd1),
    .LAST_COL  (10'd3)
  ) dut (
    .PLB_clk                (PLB_clk),
    .reset                  (reset),
    .Bus2IP_Reset           (Bus2IP_Reset),
    .frame_start            (frame_start),
    .front_buffer           (front_buffer),
    .pix_fifo_full          (pix_fifo_full),
    .pix_fifo_wr_en         (pix_fifo_wr_en),
    .pix_fifo_data          (pix_fifo_data),
    .frame_done             (frame_done),
    .busy                   (busy),
    .IP2Bus_MstRd_Req       (IP2Bus_MstRd_Req),
    .IP2Bus_MstWr_Req       (IP2Bus_MstWr_Req),
    .IP2Bus_Mst_Addr        (IP2Bus_Mst_Addr),
    .IP2Bus_Mst_BE          (IP2Bus_Mst_BE),
    .IP2Bus_Mst_Lock        (IP2Bus_Mst_Lock),
    .IP2Bus_Mst_Reset       (IP2Bus_Mst_Reset),
    .IP2Bus_MstWr_d         (IP2Bus_MstWr_d),
    .Bus2IP_Mst_CmdAck      (bm_ack),
    .Bus2IP_Mst_Cmplt       (w_cmplt),
    .Bus2IP_Mst_Error       (bm_err),
    .Bus2IP_MstRd_d         (bm_data),
    .Bus2IP_MstRd_src_rdy_n (bm_rdy_n)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pix_addr(input logic b, input int line, input int col);
    return {10'b1001_0000_00, b, 9'(line), 10'(col), 2'b00};
  endfunction

  task automatic queue_frame(input logic b);
    for (int l = 0; l <= 1; l++)
      for (int c = 0; c <= 3; c++)
        addr_q.push_back(pix_addr(b, l, c));
  endtask

  task automatic pulse_frame(input logic b);
    front_buffer = b;
    frame_start  = 1'b1;
    @(negedge PLB_clk);
    frame_start  = 1'b0;
  endtask

  task automatic wait_push();
    logic seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge PLB_clk);
      seen = pix_fifo_wr_en;
    end
    chk("push_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_done();
    logic seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge PLB_clk);
      seen = frame_done;
    end
    chk("frame_done_seen", 32'(seen), 32'd1);
  endtask

  // PLB read responder: expected address comes from the bench's own raster map.
  initial begin
    logic [31:0] exp_a;
    forever begin
      @(negedge PLB_clk);
      if (IP2Bus_MstRd_Req && bm_mode == 0) begin
        for (int i = 1; i < ack_delay; i++) begin
          @(negedge PLB_clk);
          chk("req_held", 32'(IP2Bus_MstRd_Req), 32'd1);
        end
        exp_a = (addr_q.size() != 0) ? addr_q.pop_front() : 32'hDEAD_BEEF;
        chk("rd_addr", IP2Bus_Mst_Addr, exp_a);
        bm_ack = 1'b1;
        @(negedge PLB_clk);
        bm_ack = 1'b0;
        chk("req_dropped", 32'(IP2Bus_MstRd_Req), 32'd0);
        @(negedge PLB_clk);
        bm_data  = $urandom;
        bm_rdy_n = 1'b0;
        bm_cmplt = 1'b1;
        bm_err   = (rd_cnt == err_at);
        data_q.push_back(bm_err ? C_ERR_COLOR : bm_data);
        rd_cnt++;
        @(negedge PLB_clk);
        bm_rdy_n = 1'b1;
        bm_cmplt = 1'b0;
        bm_err   = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] exp_d;
    forever begin
      @(negedge PLB_clk);
      if (pix_fifo_wr_en) begin
        n_push++;
        if (data_q.size() != 0) begin
          exp_d = data_q.pop_front();
          chk("pix_data", pix_fifo_data, exp_d);
        end else begin
          chk("spurious_push", 32'(pix_fifo_wr_en), 32'd0);
        end
      end
      if (frame_done) n_done++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0, req_cnt;
    logic seen;

    repeat (3) @(negedge PLB_clk);
    Bus2IP_Reset = 1'b0;
    @(negedge PLB_clk);
    chk("rst_req",      32'(IP2Bus_MstRd_Req), 32'd0);
    chk("rst_wr_en",    32'(pix_fifo_wr_en),   32'd0);
    chk("rst_done",     32'(frame_done),       32'd0);
    chk("rst_busy",     32'(busy),             32'd0);
    chk("rst_data",     pix_fifo_data,         32'h0);
    chk("rst_addr",     IP2Bus_Mst_Addr,       32'h9000_0000);
    chk("tie_wr_req",   32'(IP2Bus_MstWr_Req), 32'd0);
    chk("tie_be",       32'(IP2Bus_Mst_BE),    32'hF);
    chk("tie_lock",     32'(IP2Bus_Mst_Lock),  32'd0);
    chk("tie_mst_rst",  32'(IP2Bus_Mst_Reset), 32'd0);
    chk("tie_wr_d",     IP2Bus_MstWr_d,        32'h0);

    // Frame 1: buffer 1; a frame_start coinciding with the final push is ignored.
    p0 = n_push; d0 = n_done;
    queue_frame(1'b1);
    pulse_frame(1'b1);
    chk("busy_in_frame", 32'(busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      wait_push();
      if (k == 7) begin
        frame_start = 1'b1;
        @(negedge PLB_clk);
        frame_start = 1'b0;
        chk("frame_done_f1", 32'(frame_done), 32'd1);
        chk("busy_end_f1",   32'(busy),       32'd0);
      end
    end
    repeat (4) @(negedge PLB_clk);
    chk("late_start_ignored", 32'(busy),     32'd0);
    chk("f1_pushes",          32'(n_push - p0), 32'd8);
    chk("f1_done_cnt",        32'(n_done - d0), 32'd1);

    // Frame 2: FIFO full hold, error on pixel 5, ignored mid-frame restart.
    p0 = n_push; d0 = n_done;
    err_at = rd_cnt + 5;
    queue_frame(1'b1);
    pulse_frame(1'b1);
    for (int k = 0; k < 3; k++) wait_push();
    pix_fifo_full = 1'b1;
    req_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge PLB_clk);
      if (IP2Bus_MstRd_Req) req_cnt++;
    end
    chk("no_req_when_full", 32'(req_cnt), 32'd0);
    chk("busy_when_full",   32'(busy),    32'd1);
    pix_fifo_full = 1'b0;
    wait_push();
    @(negedge PLB_clk);
    pulse_frame(1'b0);
    wait_done();
    repeat (4) @(negedge PLB_clk);
    chk("f2_pushes",   32'(n_push - p0), 32'd8);
    chk("f2_done_cnt", 32'(n_done - d0), 32'd1);

    // Frame 3: buffer 0 with a slow command acknowledge.
    p0 = n_push; d0 = n_done;
    ack_delay = 10;
    queue_frame(1'b0);
    pulse_frame(1'b0);
    wait_done();
    repeat (4) @(negedge PLB_clk);
    ack_delay = 1;
    chk("f3_pushes",   32'(n_push - p0), 32'd8);
    chk("f3_done_cnt", 32'(n_done - d0), 32'd1);

    // Reset while a request is outstanding; a stray completion must not push.
    bm_mode = 1;
    p0 = n_push;
    pulse_frame(1'b1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge PLB_clk);
      seen = IP2Bus_MstRd_Req;
    end
    chk("abort_req_seen", 32'(seen), 32'd1);
    reset = 1'b1;
    @(negedge PLB_clk);
    chk("abort_req",  32'(IP2Bus_MstRd_Req), 32'd0);
    chk("abort_busy", 32'(busy),             32'd0);
    chk("abort_addr", IP2Bus_Mst_Addr,       32'h9000_0000);
    reset = 1'b0;
    tb_cmplt = 1'b1;
    @(negedge PLB_clk);
    tb_cmplt = 1'b0;
    repeat (10) @(negedge PLB_clk);
    chk("abort_no_push", 32'(n_push - p0),      32'd0);
    chk("abort_idle",    32'(busy),             32'd0);
    chk("abort_no_req",  32'(IP2Bus_MstRd_Req), 32'd0);
    bm_mode = 0;

    chk("addr_q_left", 32'(addr_q.size()), 32'd0);
    chk("data_q_left", 32'(data_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
